shifter_arbiter: RTL and testbench
==================================

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width in bits; it is a power of two and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: bit k asserts that requester k has an operation pending.
REQ-005 The block SHALL have port req_ready, output, 2 bits: bit k asserts that the operation of requester k is accepted this cycle.
REQ-006 The block SHALL have ports req_a0 and req_a1, input, WIDTH bits each: value to shift for requesters 0 and 1.
REQ-007 The block SHALL have ports req_b0 and req_b1, input, WIDTH bits each: unsigned shift amount for requesters 0 and 1.
REQ-008 The block SHALL have port req_arith, input, 2 bits: bit k set selects an arithmetic right shift for requester k; bit k clear selects a logical right shift.
REQ-009 The block SHALL have port resp_valid, output, 2 bits: bit k asserts that a result for requester k is present.
REQ-010 The block SHALL have port resp_ready, input, 2 bits: bit k asserts that requester k consumes the result this cycle.
REQ-011 The block SHALL have port resp_data, output, WIDTH bits: the shift result.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The block SHALL instantiate exactly one right_shifter #(WIDTH); both requesters share it, with at most one operation in flight.
REQ-014 The FSM SHALL have exactly three states:
- IDLE: waiting for a request.
- EXEC: the shifter input registers are stable and the result register is loaded.
- RESP: the result is presented to the owner.
REQ-015 The IDLE transitions SHALL be:
- If any req_valid bit is set, grant exactly one requester, assert its req_ready bit combinationally in that same cycle, and go to EXEC.
- Otherwise stay in IDLE with req_ready = 2'b00.
REQ-016 On a grant, the block SHALL latch the granted requester's A and B into registers, latch shift_bit = req_arith[k] & A[WIDTH-1], and record owner = k.
REQ-017 Arbitration SHALL be round-robin:
- A single valid requester is granted directly.
- When both are valid, the requester other than last_grant wins.
- last_grant updates on each grant.
- last_grant resets to 1, so requester 0 wins the first contention.
REQ-018 EXEC SHALL last exactly one cycle: the registered shifter output is loaded into the result register and the state goes to RESP.
REQ-019 In RESP, the block SHALL:
- drive resp_valid[owner] = 1;
- drive resp_valid of the other requester = 0;
- drive resp_data from the result register.
REQ-020 RESP SHALL hold until resp_ready[owner] = 1, then go to IDLE; resp_ready of the non-owner SHALL be ignored.
REQ-021 A new grant SHALL NOT occur in the cycle the response is consumed; the minimum spacing between grants is 3 cycles.
REQ-022 Latency SHALL be: a grant on edge t produces resp_valid at t+2 (the third cycle of the transaction).
REQ-023 In EXEC and RESP, req_ready SHALL be 2'b00; pending requests stay pending, and the requester holds its operands.
REQ-024 Shift amounts SHALL follow these rules, with B treated as full-width unsigned:
- B >= WIDTH gives all zeros (logical) or all copies of A[WIDTH-1] (arithmetic).
- B = 0 gives A unchanged.
REQ-025 resp_data SHALL be stable while resp_valid is high.
REQ-026 When resp_valid = 0, resp_data SHALL hold its last value.
REQ-027 Changes to requester inputs after the grant SHALL NOT affect the in-flight result.

Reset
REQ-028 rst_n = 0 SHALL immediately, without waiting for clk, set:
- state = IDLE, busy = 0;
- resp_valid = 2'b00, req_ready = 2'b00;
- resp_data = 0, owner = 0, last_grant = 1;
- the operand registers to 0.
REQ-029 A reset asserted during EXEC or RESP SHALL abort the transaction without emitting a response; after reset the requester re-issues its operation.
REQ-030 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge at which rst_n = 1.

Verification
REQ-031 The bench SHALL cover a logical shift: req0 with A=32'hF000_0000, B=4, arith=0 -> req_ready[0] in cycle 0, resp_valid[0] in cycle 2, resp_data=32'h0F00_0000.
REQ-032 The bench SHALL cover an arithmetic shift with saturation: req1 with A=32'h8000_0000, B=35, arith=1 -> resp_data=32'hFFFF_FFFF; the same operation with arith=0 -> 32'h0000_0000.
REQ-033 The bench SHALL cover contention: both requesters valid continuously, resp_ready always 1, starting from reset -> grants alternate 0,1,0,1 with 3 cycles between grants.
REQ-034 The bench SHALL cover backpressure: resp_ready[0] held 0 for 5 cycles in RESP -> resp_valid[0] and resp_data stay constant; req_ready=2'b00 for a waiting req1; req1 is granted only after the handshake completes.
REQ-035 The bench SHALL cover a mis-targeted ready: resp_ready[1]=1 while owner=0 -> no state change; the transaction completes only on resp_ready[0].
REQ-036 The bench SHALL cover reset in EXEC: rst_n pulsed low mid-transaction -> all outputs 0 immediately, no resp_valid follows, and the next contention grants requester 0.

Source files
------------

// File: rtl/shifter_arbiter_if.sv
// ============================================================================
// Module   : shifter_arbiter_if
// Brief    : Request/response bundle between two requesters and the shared shifter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface shifter_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       req_arith;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             busy;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_arith, resp_ready,
    output req_ready, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_arith, resp_ready,
    input  req_ready, resp_valid, resp_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/shifter_arbiter.sv
// ============================================================================
// Module   : shifter_arbiter (with right_shifter)
// Brief    : Two requesters share one right shifter; round-robin grant, 3-state FSM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module right_shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] y_o
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] stage [0:SHW];
  logic             oversize;

  assign stage[0] = a_i;

  // Log-depth barrel: stage s shifts by 2**s when amount bit s is set.
  for (genvar s = 0; s < SHW; s++) begin : g_stage
    localparam int D = 1 << s;
    assign stage[s+1] = b_i[s] ? {{D{fill_i}}, stage[s][WIDTH-1:D]} : stage[s];
  end

  assign oversize = |b_i[WIDTH-1:SHW];
  assign y_o      = oversize ? {WIDTH{fill_i}} : stage[SHW];
endmodule

module shifter_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  shifter_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sb_q, sb_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;

  logic [1:0]       grant;
  logic             grant_idx;
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] shift_y;

  right_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a_i    (a_q),
    .b_i    (b_q),
    .fill_i (sb_q),
    .y_o    (shift_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      sb_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      sb_q         <= sb_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    sb_d         = sb_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    grant        = 2'b00;
    grant_idx    = 1'b0;
    resp_valid   = 2'b00;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          // Under contention the requester not served last wins.
          if (bus.req_valid == 2'b11) grant_idx = ~last_grant_q;
          else                        grant_idx = bus.req_valid[1];
          grant        = grant_idx ? 2'b10 : 2'b01;
          a_d          = grant_idx ? bus.req_a1 : bus.req_a0;
          b_d          = grant_idx ? bus.req_b1 : bus.req_b0;
          sb_d         = bus.req_arith[grant_idx] & a_d[WIDTH-1];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = shift_y;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid = owner_q ? 2'b10 : 2'b01;
        if (bus.resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is combinational, so it is gated to stay low while reset is held.
  assign bus.req_ready  = grant & {2{rst_n}};
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = result_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_shifter_arbiter.sv
// ============================================================================
// Module   : tb_shifter_arbiter
// Brief    : Directed scoreboard bench for shifter_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shifter_arbiter;
  localparam int W = 32;

  typedef struct packed {
    logic [1:0]   who;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shifter_arbiter_if #(.WIDTH(W)) bus();
  shifter_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Independent bit-wise reference for the right shift.
  function automatic logic [W-1:0] model_shr(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ar);
    logic [W-1:0] r;
    logic         fill;
    int           amt;
    fill = ar & a[W-1];
    amt  = (b < W) ? int'(b) : W;
    for (int i = 0; i < W; i++) r[i] = (i + amt < W) ? a[i + amt] : fill;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ar);
    exp_t e;
    e.who  = (k == 1) ? 2'b10 : 2'b01;
    e.data = model_shr(a, b, ar);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "/sb_nonempty"}, W'(sb.size() != 0), W'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "/resp_valid"}, W'(bus.resp_valid), W'(e.who));
      chk({tag, "/resp_data"}, bus.resp_data, e.data);
    end
  endtask

  // Called at posedge+1: drives requester k, checks its grant, pushes the expected result.
  task automatic issue(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ar, input string tag);
    if (k == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
    else        begin bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_arith[k] = ar;
    bus.req_valid[k] = 1'b1;
    @(negedge clk);
    chk({tag, "/req_ready"}, W'(bus.req_ready), (k == 1) ? W'(2'b10) : W'(2'b01));
    push_exp(k, a, b, ar);
    tick();
    bus.req_valid[k] = 1'b0;
    // Scramble operands after the grant; the in-flight result must not change.
    if (k == 0) begin bus.req_a0 = $urandom; bus.req_b0 = $urandom; end
    else        begin bus.req_a1 = $urandom; bus.req_b1 = $urandom; end
    bus.req_arith[k] = ~ar;
  endtask

  // Called at posedge+1 of the EXEC cycle; lat counts negedges from the grant cycle.
  task automatic expect_resp(input string tag, input int lat);
    int n;
    @(negedge clk);
    n = 1;
    while (bus.resp_valid == 2'b00 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, W'(n), W'(lat));
    chk({tag, "/busy"}, W'(bus.busy), W'(1));
    pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic       exp_last;
  logic [1:0] cur_owner;
  logic [1:0] rr_exp;
  logic [1:0] rv_exp;
  int         w;

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_a0     = '0;
    bus.req_a1     = '0;
    bus.req_b0     = '0;
    bus.req_b1     = '0;
    bus.req_arith  = 2'b00;
    bus.resp_ready = 2'b11;

    #2;
    chk("reset/busy", W'(bus.busy), W'(0));
    chk("reset/resp_valid", W'(bus.resp_valid), W'(0));
    chk("reset/req_ready", W'(bus.req_ready), W'(0));
    chk("reset/resp_data", bus.resp_data, W'(0));
    tick();
    rst_n = 1'b1;

    // Single-requester shifts, including the shift-amount boundaries.
    issue(0, 32'hF000_0000, 32'd4, 1'b0, "lsr4");
    expect_resp("lsr4", 2);
    tick();
    issue(1, 32'h8000_0000, 32'd35, 1'b1, "asr_sat");
    expect_resp("asr_sat", 2);
    tick();
    issue(1, 32'h8000_0000, 32'd35, 1'b0, "lsr_sat");
    expect_resp("lsr_sat", 2);
    tick();
    issue(0, 32'h1234_5678, 32'd0, 1'b1, "b_zero");
    expect_resp("b_zero", 2);
    tick();
    issue(1, 32'h8000_0010, 32'd4, 1'b1, "asr4");
    expect_resp("asr4", 2);
    tick();
    issue(0, 32'hA5A5_A5A5, 32'd32, 1'b1, "asr_b_eq_w");
    expect_resp("asr_b_eq_w", 2);
    tick();
    issue(1, 32'hFFFF_FFFF, 32'd31, 1'b0, "lsr31");
    expect_resp("lsr31", 2);
    tick();

    // Contention from reset: grants alternate 0,1,0,1 every 3 cycles.
    rst_n          = 1'b0;
    bus.req_a0     = 32'h0000_FFFF; bus.req_b0 = 32'd8;
    bus.req_a1     = 32'hF000_00F0; bus.req_b1 = 32'd4;
    bus.req_arith  = 2'b10;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    tick();
    rst_n     = 1'b1;
    exp_last  = 1'b1;
    cur_owner = 2'b00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        w         = exp_last ? 0 : 1;
        exp_last  = (w == 1);
        rr_exp    = (w == 1) ? 2'b10 : 2'b01;
        cur_owner = rr_exp;
        if (w == 0) push_exp(0, bus.req_a0, bus.req_b0, bus.req_arith[0]);
        else        push_exp(1, bus.req_a1, bus.req_b1, bus.req_arith[1]);
      end else begin
        rr_exp = 2'b00;
      end
      rv_exp = (c % 3 == 2) ? cur_owner : 2'b00;
      chk($sformatf("cont%0d/req_ready", c), W'(bus.req_ready), W'(rr_exp));
      chk($sformatf("cont%0d/resp_valid", c), W'(bus.resp_valid), W'(rv_exp));
      if (c % 3 == 2) pop_check($sformatf("cont%0d", c));
    end
    tick();
    bus.req_valid = 2'b00;

    // Backpressure with a mis-targeted ready while req1 waits.
    bus.resp_ready = 2'b10;
    issue(0, 32'hC000_0000, 32'd2, 1'b1, "bp");
    bus.req_a1 = 32'h0000_0F00; bus.req_b1 = 32'd8; bus.req_arith[1] = 1'b0;
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("bp/exec_req_ready", W'(bus.req_ready), W'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d/resp_valid", i), W'(bus.resp_valid), W'(2'b01));
      chk($sformatf("bp%0d/resp_data", i), bus.resp_data, sb[0].data);
      chk($sformatf("bp%0d/req_ready", i), W'(bus.req_ready), W'(0));
    end
    tick();
    bus.resp_ready = 2'b01;
    @(negedge clk);
    pop_check("bp_release");
    tick();
    bus.resp_ready = 2'b11;
    @(negedge clk);
    chk("bp/req1_grant", W'(bus.req_ready), W'(2'b10));
    push_exp(1, bus.req_a1, bus.req_b1, bus.req_arith[1]);
    tick();
    bus.req_valid = 2'b00;
    expect_resp("bp_req1", 2);
    tick();

    // Reset during EXEC aborts the transaction; requester 0 wins afterwards.
    bus.req_a0 = 32'hDEAD_BEEF; bus.req_b0 = 32'd4; bus.req_arith[0] = 1'b0;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("rst/pre_grant", W'(bus.req_ready), W'(2'b01));
    tick();
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst/busy", W'(bus.busy), W'(0));
    chk("rst/resp_valid", W'(bus.resp_valid), W'(0));
    chk("rst/req_ready", W'(bus.req_ready), W'(0));
    chk("rst/resp_data", bus.resp_data, W'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/regrant", W'(bus.req_ready), W'(2'b01));
    chk("rst/no_stale_resp", W'(bus.resp_valid), W'(0));
    push_exp(0, bus.req_a0, bus.req_b0, bus.req_arith[0]);
    tick();
    bus.req_valid = 2'b00;
    expect_resp("rst_regrant", 2);
    tick();

    chk("sb_empty", W'(sb.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
